// File: rtl/rx_gate_ctrl_pkg.sv
// Shared register map, CTRL bit indices and FSM state encoding for the rx gate controller.
package rx_gate_ctrl_pkg;

  localparam logic [1:0] CTRL_OFS    = 2'd0;
  localparam logic [1:0] TIMING_OFS  = 2'd1;
  localparam logic [1:0] HOLDOFF_OFS = 2'd2;

  localparam int unsigned CTRL_ENABLE    = 0;
  localparam int unsigned CTRL_POLARITY  = 1;
  localparam int unsigned CTRL_ONESHOT   = 2;
  localparam int unsigned CTRL_BYPASS    = 3;
  localparam int unsigned CTRL_CLR_STATS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_WINDOW,
    ST_HOLDOFF,
    ST_DONE
  } gate_state_t;

  function automatic logic [6:0] reg_addr(input logic [6:0] base, input logic [1:0] ofs);
    return base + 7'(ofs);
  endfunction

endpackage

// File: rtl/rx_gate_ctrl_sync.sv
// Two-flop trigger synchroniser, third flop for edge detect, polarity applied after sync.
module rx_gate_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic trig_in,
  input  logic polarity,
  output logic trig_level,
  output logic trig_edge
);

  logic sync1, sync2, sync3, edge_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= trig_in;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= (sync2 ^ polarity) & ~(sync3 ^ polarity);
    end
  end

  assign trig_level = sync2 ^ polarity;
  assign trig_edge  = edge_q;

endmodule

// File: rtl/rx_gate_ctrl.sv
// Trigger-to-gate window controller feeding rx_buffer_ge; counts are in sample_strobe units.
// Optional window statistics counter built when RX_GATE_STATS_EN is defined.
module rx_gate_ctrl
  import rx_gate_ctrl_pkg::*;
#(
  parameter logic [6:0]  FR_BASE = 7'd80,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        trig_in,
  input  logic        sample_strobe,
  output logic        gate_enable,
  output logic        gate_start,
  output logic        armed,
  output logic        missed,
  output logic [31:0] gate_count
);

  logic             ctrl_wr, timing_wr, holdoff_wr;
  logic [3:0]       ctrl_q;
  logic [CNT_W-1:0] delay_q, width_q, holdoff_q;
  logic             enable, oneshot, bypass;
  logic             trig_level, trig_edge;

  gate_state_t      state, state_nxt;
  gate_state_t      rest_st, ho_st, win_st, dly_st;
  logic [CNT_W-1:0] cnt, cnt_nxt, ho_cnt, win_cnt, dly_cnt;
  logic             start_q, missed_q, cnt_last;

  assign ctrl_wr    = serial_strobe && (serial_addr == reg_addr(FR_BASE, CTRL_OFS));
  assign timing_wr  = serial_strobe && (serial_addr == reg_addr(FR_BASE, TIMING_OFS));
  assign holdoff_wr = serial_strobe && (serial_addr == reg_addr(FR_BASE, HOLDOFF_OFS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      delay_q   <= '0;
      width_q   <= '0;
      holdoff_q <= '0;
    end else begin
      if (ctrl_wr)    ctrl_q    <= serial_data[3:0];
      if (timing_wr) begin
        delay_q <= CNT_W'(serial_data[15:0]);
        width_q <= CNT_W'(serial_data[31:16]);
      end
      if (holdoff_wr) holdoff_q <= CNT_W'(serial_data[15:0]);
    end
  end

  assign enable  = ctrl_q[CTRL_ENABLE];
  assign oneshot = ctrl_q[CTRL_ONESHOT];
  assign bypass  = ctrl_q[CTRL_BYPASS];

  rx_gate_sync u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .trig_in    (trig_in),
    .polarity   (ctrl_q[CTRL_POLARITY]),
    .trig_level (trig_level),
    .trig_edge  (trig_edge)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      start_q <= (state_nxt == ST_WINDOW) && (state != ST_WINDOW);
    end
  end

  // Zero-length phases collapse into the next load: delay -> width -> holdoff -> rest.
  always_comb begin
    rest_st = oneshot ? ST_DONE : ST_IDLE;
    if (holdoff_q != '0) begin
      ho_st  = ST_HOLDOFF;
      ho_cnt = holdoff_q;
    end else begin
      ho_st  = rest_st;
      ho_cnt = '0;
    end
    if (width_q != '0) begin
      win_st  = ST_WINDOW;
      win_cnt = width_q;
    end else begin
      win_st  = ho_st;
      win_cnt = ho_cnt;
    end
    if (delay_q != '0) begin
      dly_st  = ST_DELAY;
      dly_cnt = delay_q;
    end else begin
      dly_st  = win_st;
      dly_cnt = win_cnt;
    end

    cnt_last  = sample_strobe && (cnt == CNT_W'(1));
    state_nxt = state;
    cnt_nxt   = cnt;

    // A CTRL write clearing enable aborts on the same edge it lands.
    if (bypass || !enable || (ctrl_wr && !serial_data[CTRL_ENABLE])) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: if (trig_edge) begin
          state_nxt = dly_st;
          cnt_nxt   = dly_cnt;
        end
        ST_DELAY: if (cnt_last) begin
          state_nxt = win_st;
          cnt_nxt   = win_cnt;
        end else if (sample_strobe) begin
          cnt_nxt = cnt - CNT_W'(1);
        end
        ST_WINDOW: if (cnt_last) begin
          state_nxt = ho_st;
          cnt_nxt   = ho_cnt;
        end else if (sample_strobe) begin
          cnt_nxt = cnt - CNT_W'(1);
        end
        ST_HOLDOFF: if (cnt_last) begin
          state_nxt = rest_st;
          cnt_nxt   = '0;
        end else if (sample_strobe) begin
          cnt_nxt = cnt - CNT_W'(1);
        end
        ST_DONE: if (ctrl_wr && serial_data[CTRL_ENABLE]) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     missed_q <= 1'b0;
    else if (ctrl_wr) missed_q <= 1'b0;
    else if (trig_edge && (state != ST_IDLE)) missed_q <= 1'b1;
  end

  always_comb begin
    gate_enable = bypass ? trig_level : (state == ST_WINDOW);
    gate_start  = start_q;
    armed       = (state == ST_IDLE) && enable;
    missed      = missed_q;
  end

`ifdef RX_GATE_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                     count_q <= '0;
    else if (ctrl_wr && serial_data[CTRL_CLR_STATS]) count_q <= '0;
    else if (start_q)                                 count_q <= count_q + 32'd1;
  end

  assign gate_count = count_q;
`else
  assign gate_count = '0;
`endif

endmodule
